// File: rtl/fsk_bit_receiver_if.sv
// FSK receiver line and result bus: fsk_in toward the receiver, decoded byte and status back.
interface fsk_bit_receiver_if;
    logic       fsk_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       carrier_lost;
    logic       busy;

    modport master (output fsk_in, input data_out, data_valid, parity_err, carrier_lost, busy);
    modport slave  (input fsk_in, output data_out, data_valid, parity_err, carrier_lost, busy);
endinterface

// File: rtl/fsk_bit_receiver.sv
// FSK bit receiver: counts line transitions per bit window and frames 8 data bits plus parity.
// Optional macro FSK_RX_PARITY_CHECK_EN enables the even-parity check on the 9th bit.
module fsk_bit_receiver #(
    parameter int BIT_CYCLES = 16,
    parameter int ONE_THRESH = 6,
    parameter int MIN_EDGES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    fsk_bit_receiver_if.slave bus
);
    localparam int WW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t        state;
    logic          prev_in;
    logic [WW-1:0] wcnt;
    logic [4:0]    ecnt;
    logic [3:0]    bidx;
    logic [8:0]    shift;
    logic [7:0]    dout_r;
    logic          dv_r, perr_r, cl_r, busy_r;

    logic          edge_det, wend, bit_nx;
    logic [4:0]    ecnt_nx;
    logic [8:0]    shift_nx;

    assign edge_det = bus.fsk_in ^ prev_in;
    assign wend     = (wcnt == WW'(BIT_CYCLES - 1));
    // Count includes the current cycle's edge so the last window cycle is not lost.
    assign ecnt_nx  = (ecnt == 5'd31) ? 5'd31 : ecnt + {4'd0, edge_det};
    assign bit_nx   = (ecnt_nx >= 5'(ONE_THRESH));
    assign shift_nx = {shift[7:0], bit_nx};

`ifndef FSK_RX_PARITY_CHECK_EN
    logic unused_msb;
    assign unused_msb = shift[8];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            prev_in <= 1'b0;
            wcnt    <= '0;
            ecnt    <= '0;
            bidx    <= '0;
            shift   <= '0;
            dout_r  <= '0;
            dv_r    <= 1'b0;
            perr_r  <= 1'b0;
            cl_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            prev_in <= bus.fsk_in;
            dv_r    <= 1'b0;
            cl_r    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // The starting edge is window cycle 0 of bit 0.
                    if (edge_det) begin
                        state  <= COLLECT;
                        busy_r <= 1'b1;
                        wcnt   <= WW'(1);
                        ecnt   <= 5'd1;
                        bidx   <= '0;
                        shift  <= '0;
                    end else begin
                        state  <= IDLE;
                    end
                end
                COLLECT: begin
                    if (wend) begin
                        wcnt <= '0;
                        ecnt <= '0;
                        if (ecnt_nx < 5'(MIN_EDGES)) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            cl_r   <= 1'b1;
                            shift  <= '0;
                            bidx   <= '0;
                        end else begin
                            shift <= shift_nx;
                            bidx  <= bidx + 4'd1;
                            if (bidx == 4'd8) begin
                                state  <= DONE;
                                busy_r <= 1'b0;
                                dout_r <= shift_nx[8:1];
                                dv_r   <= 1'b1;
`ifdef FSK_RX_PARITY_CHECK_EN
                                perr_r <= ^shift_nx;
`else
                                perr_r <= 1'b0;
`endif
                            end
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        ecnt <= ecnt_nx;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out     = dout_r;
    assign bus.data_valid   = dv_r;
    assign bus.parity_err   = perr_r;
    assign bus.carrier_lost = cl_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_fsk_bit_receiver.sv
// Directed bench for fsk_bit_receiver: FSK transmitter model plus scoreboard of expected bytes.
module tb_fsk_bit_receiver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fsk_bit_receiver_if bus();
    fsk_bit_receiver dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0, n_fail = 0, cyc = 0, dv_seen = 0, cl_seen = 0;
    logic line = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every data_valid pops one expected frame, including its cycle.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            dv_seen++;
            if (q.size() == 0) chk("dv_unexpected", 32'(q.size()), 1);
            else begin
                e = q.pop_front();
                chk("data_out", {24'd0, bus.data_out}, {24'd0, e.d});
                chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.p});
                chk("dv_cycle", cyc, e.c);
            end
        end
        if (bus.carrier_lost === 1'b1) cl_seen++;
    end

    task automatic drive(input logic v);
        bus.fsk_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int per;
        per = b ? 2 : 4;
        for (int c = 0; c < 16; c++) begin
            if (c % per == 0) line = ~line;
            drive(line);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        exp_t x;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(p);
        x.d = d;
`ifdef FSK_RX_PARITY_CHECK_EN
        x.p = ^{d, p};
`else
        x.p = 1'b0;
`endif
        x.c = cyc;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(line);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
        chk({tag, "_dv"}, {31'd0, bus.data_valid}, 0);
        chk({tag, "_cl"}, {31'd0, bus.carrier_lost}, 0);
        chk({tag, "_perr"}, {31'd0, bus.parity_err}, 0);
        chk({tag, "_dout"}, {24'd0, bus.data_out}, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.fsk_in = 1'b0;
        repeat (3) drive(1'b0);
        chk_reset_outs("rst");
        reset = 1'b0;
        repeat (100) drive(1'b0);
        chk_reset_outs("quiet");
        chk("quiet_dvcnt", dv_seen, 0);

        // 0xA5 with correct parity; busy during the frame
        send_bit(1'b1);
        chk("busy_mid", {31'd0, bus.busy}, 1);
        for (int i = 6; i >= 0; i--) send_bit(8'hA5 >> i);
        send_bit(1'b0);
        e.d = 8'hA5; e.p = 1'b0; e.c = cyc;
        q.push_back(e);
        chk("done_busy", {31'd0, bus.busy}, 0);
        idle(5);
        chk("hold_dout", {24'd0, bus.data_out}, 32'hA5);
        chk("hold_dv", {31'd0, bus.data_valid}, 0);

        // 0xA5 with bad parity
        send_frame(8'hA5, 1'b1);
        idle(5);
`ifdef FSK_RX_PARITY_CHECK_EN
        chk("hold_perr", {31'd0, bus.parity_err}, 1);
`else
        chk("hold_perr", {31'd0, bus.parity_err}, 0);
`endif

        // back to back frames, no gap
        send_frame(8'h3C, 1'b0);
        send_frame(8'hFF, 1'b0);
        idle(5);
        chk("b2b_dout", {24'd0, bus.data_out}, 32'hFF);
        chk("b2b_dvcnt", dv_seen, 4);

        // carrier loss after 4 bits of 0x81
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        idle(15);
        chk("pre_cl", {31'd0, bus.carrier_lost}, 0);
        idle(1);
        chk("cl_pulse", {31'd0, bus.carrier_lost}, 1);
        chk("cl_busy", {31'd0, bus.busy}, 0);
        idle(1);
        chk("cl_single", {31'd0, bus.carrier_lost}, 0);
        chk("cl_dvcnt", dv_seen, 4);
        chk("cl_dout", {24'd0, bus.data_out}, 32'hFF);
        idle(10);
        send_frame(8'h55, 1'b0);
        idle(5);

        // reset in the middle of bit 6
        for (int i = 7; i >= 2; i--) send_bit(8'h5A >> i);
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) line = ~line;
            drive(line);
        end
        reset = 1'b1;
        line = 1'b0;
        drive(1'b0);
        chk_reset_outs("midrst");
        reset = 1'b0;
        idle(20);
        chk("midrst_dvcnt", dv_seen, 5);
        chk("midrst_clcnt", cl_seen, 1);
        send_frame(8'h5A, 1'b0);
        idle(5);

        chk("end_q_empty", 32'(q.size()), 0);
        chk("end_dvcnt", dv_seen, 6);
        chk("end_clcnt", cl_seen, 1);
        chk("end_dout", {24'd0, bus.data_out}, 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fsk_bit_receiver.md
FSK_BIT_RECEIVER -- requirements
Module: fsk_bit_receiver

Interface
REQ-001 Parameter BIT_CYCLES, 16: clk cycles per received bit window.
REQ-002 Parameter ONE_THRESH, 6: minimum transitions in a window for a decision of 1.
REQ-003 Parameter MIN_EDGES, 2: fewer transitions than this in a window means carrier lost.
REQ-004 clk  input  1  receive sample clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fsk_in  input  1  FSK line. Tone "1" toggles every 2 clk; tone "0" toggles every 4 clk.
REQ-007 data_out  output  8  last received data byte, MSB first on the line.
REQ-008 data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-009 parity_err  output  1  qualified by data_valid; even-parity check failed.
REQ-010 carrier_lost  output  1  one-cycle pulse on a frame abort.
REQ-011 busy  output  1  high while in state COLLECT.

Function
REQ-012 Edge detect: register fsk_in into prev_in each cycle; edge = fsk_in XOR prev_in.
REQ-013 FSM states:
- IDLE: waits for the first edge.
- COLLECT: receives 9 bit windows back to back.
- DONE: single cycle; presents the result.
REQ-014 IDLE -> COLLECT on an edge. That cycle is window cycle 0 of bit 0, and its edge counts as 1.
REQ-015 Window counter runs 0..BIT_CYCLES-1 and wraps.
- Edge counter is 5 bits, saturates at 31, and counts edges including any on the last cycle.
- At wrap the counter reloads to 0, or to 1 if the wrap cycle's successor has an edge.
REQ-016 At the last window cycle:
- bit = (count >= ONE_THRESH).
- The bit shifts into a 9-bit register, MSB first.
- The bit index increments.
REQ-017 Carrier loss: if count < MIN_EDGES at window end, go to IDLE.
- Pulse carrier_lost the next cycle.
- Discard the partial word.
- data_out and data_valid are unaffected.
REQ-018 After the bit-8 window ends, go to DONE.
REQ-019 In DONE:
- data_out = shift[8:1].
- parity_err = XOR of all 9 bits.
- data_valid = 1 for exactly this cycle.
- Latency: 1 cycle after the last sample of bit 8.
REQ-020 DONE -> COLLECT if an edge occurs in the DONE cycle; this starts the next frame with count 1.
- Otherwise DONE -> IDLE.
REQ-021 data_out and parity_err hold their values until the next DONE.
REQ-022 An edge during DONE is never lost.
- An edge arriving exactly at a carrier abort is ignored.
- IDLE then waits for the next edge.

Reset
REQ-023 Synchronous reset applies on any cycle, including mid-frame. It sets:
- state = IDLE; all counters and the shift register = 0; prev_in = 0.
- data_out = 0x00; data_valid = 0; parity_err = 0; carrier_lost = 0; busy = 0.
REQ-024 Reset asserted mid-frame produces no data_valid or carrier_lost pulse for the discarded frame.

Configuration
REQ-025 Macro FSK_RX_PARITY_CHECK_EN.
- Defined: parity is computed per REQ-019, and a frame with a parity error still raises data_valid.
- Undefined: parity_err is tied to 0, and the 9th bit is received but ignored.
- In both builds, frame length stays 9 bits.

Verification
REQ-026 Release reset; hold fsk_in=0 for 100 cycles -> busy=0, data_valid=0, carrier_lost=0, data_out=0x00.
REQ-027 Send byte 0xA5 with parity 0 (bits 1,0,1,0,0,1,0,1,0; 144 cycles) -> one data_valid pulse 1 cycle after the last sample, data_out=0xA5, parity_err=0.
REQ-028 Send 0xA5 with parity bit 1 -> data_out=0xA5, parity_err=1 (0 in the build without FSK_RX_PARITY_CHECK_EN).
REQ-029 Send 0x3C then 0xFF back to back with no gap -> two data_valid pulses, 144 cycles apart, data_out 0x3C then 0xFF.
REQ-030 Send 4 bits of 0x81, then hold fsk_in constant -> carrier_lost pulse at the end of the 5th window, no data_valid, and busy falls; a following 0x55 frame is received correctly.
REQ-031 Assert reset for 1 cycle at bit 6 of a frame -> all outputs at reset values next cycle, no pulses, and the next full frame decodes correctly.
